// File: rtl/commit_ctrl_np.sv
// N-port in-order commit controller: slot acks, write enables, fence-drain and AMO FSM,
// sticky FP flags and retire counter. Optional stall counter under COMMIT_CTRL_PERF_CNT_EN.
module commit_ctrl_np #(
    parameter int unsigned NR_PORTS      = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned CNT_W         = 64,
    parameter int unsigned FENCE_TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     halt_i,
    input  logic                     single_step_i,
    input  logic [NR_PORTS-1:0]      valid_i,
    input  logic [NR_PORTS-1:0]      ex_valid_i,
    input  logic [NR_PORTS*XLEN-1:0] ex_cause_i,
    input  logic [NR_PORTS*3-1:0]    op_class_i,
    input  logic [NR_PORTS*5-1:0]    rd_i,
    input  logic [NR_PORTS-1:0]      rd_fpr_i,
    input  logic [NR_PORTS*XLEN-1:0] result_i,
    input  logic [NR_PORTS*5-1:0]    fflags_i,
    input  logic                     lsu_ready_i,
    input  logic                     no_st_pending_i,
    input  logic                     csr_ex_i,
    input  logic [XLEN-1:0]          csr_rdata_i,
    input  logic                     amo_ack_i,
    input  logic [XLEN-1:0]          amo_result_i,
    input  logic                     fflags_clr_i,
    output logic [NR_PORTS-1:0]      commit_ack_o,
    output logic [NR_PORTS-1:0]      we_gpr_o,
    output logic [NR_PORTS-1:0]      we_fpr_o,
    output logic [NR_PORTS*5-1:0]    waddr_o,
    output logic [NR_PORTS*XLEN-1:0] wdata_o,
    output logic                     commit_lsu_o,
    output logic                     commit_csr_o,
    output logic                     amo_valid_commit_o,
    output logic                     fence_o,
    output logic                     flush_commit_o,
    output logic                     fence_timeout_o,
    output logic                     exception_valid_o,
    output logic [XLEN-1:0]          exception_cause_o,
    output logic [4:0]               fflags_acc_o,
    output logic [CNT_W-1:0]         retire_cnt_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam logic [2:0] OpAlu   = 3'd0;
    localparam logic [2:0] OpLoad  = 3'd1;
    localparam logic [2:0] OpStore = 3'd2;
    localparam logic [2:0] OpCsr   = 3'd3;
    localparam logic [2:0] OpFpu   = 3'd4;
    localparam logic [2:0] OpFence = 3'd5;
    localparam logic [2:0] OpAmo   = 3'd6;
    localparam logic [2:0] OpCtrl  = 3'd7;

    localparam int unsigned     TmoW    = $clog2(FENCE_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(FENCE_TIMEOUT);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(FENCE_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StAmoWait} state_e;

    state_e             state_q, state_d;
    logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [4:0]         fflags_q, fflags_d, fflags_new;
    logic [CNT_W-1:0]   retire_q, retire_d, retire_inc;
    logic [2:0]         cls0, slot_cls;
    logic               exc_valid, chain, serial, slot_ok;

    assign cls0 = op_class_i[2:0];

    // Only slot 0 can trap; younger slots' causes are never reported.
    if (NR_PORTS > 1) begin : g_unused
        logic unused_ex_cause;
        assign unused_ex_cause = ^ex_cause_i[NR_PORTS*XLEN-1:XLEN];
    end

    assign exc_valid = !rst_i && valid_i[0] && !halt_i
                       && (ex_valid_i[0] || (cls0 == OpCsr && csr_ex_i));
    assign exception_valid_o = exc_valid;
    assign exception_cause_o = rst_i         ? '0 :
                               ex_valid_i[0] ? ex_cause_i[XLEN-1:0] : XLEN'(2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i[0] && !ex_valid_i[0] && !halt_i) begin
                    if (cls0 == OpFence) begin
                        state_d = StDrain;
                    end else if (cls0 == OpAmo) begin
                        state_d = StAmoWait;
                    end
                end
            end
            StDrain:   if (!halt_i && no_st_pending_i) state_d = StIdle;
            StAmoWait: if (!halt_i && amo_ack_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        commit_ack_o       = '0;
        we_gpr_o           = '0;
        we_fpr_o           = '0;
        waddr_o            = '0;
        wdata_o            = '0;
        commit_lsu_o       = 1'b0;
        commit_csr_o       = 1'b0;
        amo_valid_commit_o = 1'b0;
        fence_o            = 1'b0;
        flush_commit_o     = 1'b0;
        fence_timeout_o    = 1'b0;
        chain              = 1'b0;
        serial             = 1'b0;
        slot_ok            = 1'b0;
        slot_cls           = '0;
        if (!rst_i) begin
            waddr_o = rd_i;
            wdata_o = result_i;
            if (cls0 == OpCsr) begin
                wdata_o[XLEN-1:0] = csr_rdata_i;
            end else if (cls0 == OpAmo) begin
                wdata_o[XLEN-1:0] = amo_result_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (valid_i[0] && !ex_valid_i[0] && !halt_i) begin
                        unique case (cls0)
                            OpStore: begin
                                commit_ack_o[0] = lsu_ready_i;
                                commit_lsu_o    = lsu_ready_i;
                            end
                            OpCsr: begin
                                commit_ack_o[0] = !csr_ex_i;
                                commit_csr_o    = !csr_ex_i;
                            end
                            OpFence, OpAmo: commit_ack_o[0] = 1'b0;
                            default:        commit_ack_o[0] = 1'b1;
                        endcase
                        if (cls0 != OpStore) begin
                            we_fpr_o[0] = commit_ack_o[0] & rd_fpr_i[0];
                            we_gpr_o[0] = commit_ack_o[0] & !rd_fpr_i[0];
                        end
                    end
                end
                StDrain: begin
                    commit_ack_o[0] = !halt_i && no_st_pending_i;
                    fence_o         = commit_ack_o[0];
                    flush_commit_o  = commit_ack_o[0];
                    fence_timeout_o = (tmo_cnt_q == TmoLast);
                end
                StAmoWait: begin
                    amo_valid_commit_o = 1'b1;
                    commit_ack_o[0]    = !halt_i && amo_ack_i;
                    we_gpr_o[0]        = commit_ack_o[0];
                    flush_commit_o     = commit_ack_o[0];
                end
                default: commit_ack_o[0] = 1'b0;
            endcase
            // Younger slots retire only behind an unbroken chain of simple acks.
            chain  = commit_ack_o[0];
            serial = cls0 inside {OpCsr, OpFence, OpAmo};
            for (int i = 1; i < NR_PORTS; i++) begin
                slot_cls = op_class_i[i*3 +: 3];
                slot_ok  = chain && !serial && valid_i[i] && !ex_valid_i[i] && !single_step_i
                           && !exc_valid && (slot_cls inside {OpAlu, OpLoad, OpCtrl, OpFpu});
                commit_ack_o[i] = slot_ok;
                we_fpr_o[i]     = slot_ok & rd_fpr_i[i];
                we_gpr_o[i]     = slot_ok & !rd_fpr_i[i];
                chain           = slot_ok;
                serial          = serial | (slot_cls inside {OpCsr, OpFence, OpAmo});
            end
        end
    end

    // Counter saturates at FENCE_TIMEOUT so the timeout pulse fires once per fence.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StDrain && state_d == StDrain) begin
            tmo_cnt_d = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        fflags_new = '0;
        retire_inc = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (commit_ack_o[i] && op_class_i[i*3 +: 3] == OpFpu) begin
                fflags_new = fflags_new | fflags_i[i*5 +: 5];
            end
            retire_inc = retire_inc + CNT_W'(commit_ack_o[i]);
        end
        fflags_d = (fflags_clr_i ? 5'd0 : fflags_q) | fflags_new;
        retire_d = retire_q + retire_inc;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            fflags_q  <= '0;
            retire_q  <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            fflags_q  <= fflags_d;
            retire_q  <= retire_d;
        end
    end

    assign fflags_acc_o = fflags_q;
    assign retire_cnt_o = retire_q;

`ifdef COMMIT_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (valid_i[0] && !commit_ack_o[0] && !exc_valid) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_commit_ctrl_np.sv
// Directed bench for commit_ctrl_np: a vector table for single-cycle commit decisions plus
// hand-written sequences for store wait, fence drain/timeout, AMO wait and the FP flag accumulator.
module tb_commit_ctrl_np;

    localparam logic [2:0] ALU = 3'd0, LOAD = 3'd1, STORE = 3'd2, CSR = 3'd3;
    localparam logic [2:0] FPU = 3'd4, FENCE = 3'd5, AMO = 3'd6, CTRL = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         halt, sstep, lsu_rdy, no_st, csr_ex, amo_ack, fclr;
    logic [3:0]   valid, exv, fpr;
    logic [255:0] ex_cause, result;
    logic [11:0]  cls;
    logic [19:0]  rd, fflags;
    logic [63:0]  csr_rdata, amo_result;
    logic [3:0]   ack, we_gpr, we_fpr;
    logic [19:0]  waddr;
    logic [255:0] wdata;
    logic         commit_lsu, commit_csr, amo_vc, fence, flush, fence_to, exc;
    logic [63:0]  exc_cause, retire_cnt, stall_cnt;
    logic [4:0]   facc;

    int n_vec  = 0;
    int n_fail = 0;
    int n_to;

    always #5 clk = ~clk;

    commit_ctrl_np #(
        .NR_PORTS(4), .XLEN(64), .CNT_W(64), .FENCE_TIMEOUT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(sstep),
        .valid_i(valid), .ex_valid_i(exv), .ex_cause_i(ex_cause), .op_class_i(cls),
        .rd_i(rd), .rd_fpr_i(fpr), .result_i(result), .fflags_i(fflags),
        .lsu_ready_i(lsu_rdy), .no_st_pending_i(no_st), .csr_ex_i(csr_ex),
        .csr_rdata_i(csr_rdata), .amo_ack_i(amo_ack), .amo_result_i(amo_result),
        .fflags_clr_i(fclr),
        .commit_ack_o(ack), .we_gpr_o(we_gpr), .we_fpr_o(we_fpr), .waddr_o(waddr),
        .wdata_o(wdata), .commit_lsu_o(commit_lsu), .commit_csr_o(commit_csr),
        .amo_valid_commit_o(amo_vc), .fence_o(fence), .flush_commit_o(flush),
        .fence_timeout_o(fence_to), .exception_valid_o(exc), .exception_cause_o(exc_cause),
        .fflags_acc_o(facc), .retire_cnt_o(retire_cnt), .stall_cnt_o(stall_cnt)
    );

    typedef struct {
        logic        halt, sstep, lsu_rdy, csr_ex;
        logic [3:0]  valid, exv, fpr;
        logic [11:0] cls;
        logic [3:0]  e_ack, e_gpr, e_fpr;
        logic        e_lsu, e_csr, e_exc;
        logic [63:0] e_cause;
    } vec_t;

    vec_t vq[$];

    function automatic logic [11:0] cl(input logic [2:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic add(input logic h, ss, lr, ce, input logic [3:0] v, x, f,
                       input logic [11:0] c, input logic [3:0] ea, eg, ef,
                       input logic el, ec, ee, input logic [63:0] cause);
        vec_t t;
        t.halt = h; t.sstep = ss; t.lsu_rdy = lr; t.csr_ex = ce;
        t.valid = v; t.exv = x; t.fpr = f; t.cls = c;
        t.e_ack = ea; t.e_gpr = eg; t.e_fpr = ef;
        t.e_lsu = el; t.e_csr = ec; t.e_exc = ee; t.e_cause = cause;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic defaults();
        halt = 0; sstep = 0; lsu_rdy = 1; no_st = 0; csr_ex = 0; amo_ack = 0; fclr = 0;
        valid = 0; exv = 0; fpr = 0; cls = 0; fflags = 0;
        ex_cause   = 256'd13;
        rd         = {5'd4, 5'd3, 5'd2, 5'd1};
        result     = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
        csr_rdata  = 64'hC5C5;
        amo_result = 64'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        defaults();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        defaults();
        rst   = 1;
        valid = 4'hF;
        // Reset: outputs held low, registers cleared.
        @(negedge clk); #1;
        chk("rst.ack", ack, 0);
        chk("rst.waddr", waddr, 0);
        @(negedge clk); #1;
        chk("rst.retire", retire_cnt, 0);
        chk("rst.facc", facc, 0);
        chk("rst.stall", stall_cnt, 0);
        chk("rst.amo_vc", amo_vc, 0);
        rst = 0;

        //  h  ss lr ce valid  exv    fpr    classes                      ack    gpr    fpr   lsu csr exc cause
        add(0, 0, 1, 0, 4'hF, 4'h0, 4'h0, cl(ALU, ALU, ALU, ALU),    4'hF, 4'hF, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hF, 4'h0, 4'h4, cl(ALU, LOAD, FPU, CTRL),  4'hF, 4'hB, 4'h4, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hB, 4'h0, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h3, 4'h3, 4'h0, 0, 0, 0, 2);
        add(0, 1, 1, 0, 4'hF, 4'h0, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h1, 4'h1, 4'h0, 0, 0, 0, 2);
        add(1, 0, 1, 0, 4'hF, 4'h0, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h0, 4'h0, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hF, 4'h0, 4'h0, cl(STORE, ALU, ALU, ALU),  4'hF, 4'hE, 4'h0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 4'hF, 4'h0, 4'h0, cl(STORE, ALU, ALU, ALU),  4'h0, 4'h0, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hF, 4'h0, 4'h0, cl(CSR, ALU, ALU, ALU),    4'h1, 4'h1, 4'h0, 0, 1, 0, 2);
        add(0, 0, 1, 1, 4'hF, 4'h0, 4'h0, cl(CSR, ALU, ALU, ALU),    4'h0, 4'h0, 4'h0, 0, 0, 1, 2);
        add(0, 0, 1, 0, 4'h3, 4'h1, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h0, 4'h0, 4'h0, 0, 0, 1, 13);
        add(1, 0, 1, 0, 4'h3, 4'h1, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h0, 4'h0, 4'h0, 0, 0, 0, 13);
        add(0, 0, 1, 0, 4'hF, 4'h0, 4'h0, cl(ALU, STORE, ALU, ALU),  4'h1, 4'h1, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hF, 4'h4, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h3, 4'h3, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hF, 4'h0, 4'h0, cl(ALU, CSR, ALU, ALU),    4'h1, 4'h1, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 4'hE, 4'h0, 4'h0, cl(ALU, ALU, ALU, ALU),    4'h0, 4'h0, 4'h0, 0, 0, 0, 2);
        add(0, 0, 1, 1, 4'hF, 4'h1, 4'h0, cl(CSR, ALU, ALU, ALU),    4'h0, 4'h0, 4'h0, 0, 0, 1, 13);

        foreach (vq[k]) begin
            @(negedge clk);
            halt = vq[k].halt; sstep = vq[k].sstep; lsu_rdy = vq[k].lsu_rdy;
            csr_ex = vq[k].csr_ex; valid = vq[k].valid; exv = vq[k].exv;
            fpr = vq[k].fpr; cls = vq[k].cls;
            #1;
            chk($sformatf("v%0d.ack", k), ack, vq[k].e_ack);
            chk($sformatf("v%0d.we_gpr", k), we_gpr, vq[k].e_gpr);
            chk($sformatf("v%0d.we_fpr", k), we_fpr, vq[k].e_fpr);
            chk($sformatf("v%0d.lsu", k), commit_lsu, vq[k].e_lsu);
            chk($sformatf("v%0d.csr", k), commit_csr, vq[k].e_csr);
            chk($sformatf("v%0d.exc", k), exc, vq[k].e_exc);
            chk($sformatf("v%0d.cause", k), exc_cause, vq[k].e_cause);
        end

        // Four ALU slots retire together and bump the counter by 4.
        do_reset();
        @(negedge clk);
        valid = 4'hF; cls = cl(ALU, ALU, ALU, ALU);
        #1;
        chk("ret.ack", ack, 4'hF);
        chk("ret.waddr", waddr, {5'd4, 5'd3, 5'd2, 5'd1});
        chk("ret.wdata0", wdata[63:0], 64'h1111);
        @(negedge clk);
        valid = 0;
        #1;
        chk("ret.cnt", retire_cnt, 4);
        @(negedge clk); #1;
        chk("ret.hold", retire_cnt, 4);

        // Store waits for the LSU; slot 1 ALU follows in the same cycle.
        do_reset();
        valid = 4'h3; cls = cl(STORE, ALU, ALU, ALU); lsu_rdy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("st.wait%0d.ack", k), ack, 0);
            chk($sformatf("st.wait%0d.lsu", k), commit_lsu, 0);
        end
        @(negedge clk);
        lsu_rdy = 1;
        #1;
        chk("st.ack", ack, 4'h3);
        chk("st.lsu", commit_lsu, 1);
        chk("st.we_gpr", we_gpr, 4'h2);
        @(negedge clk);
        valid = 0;
        #1;
        chk("st.cnt", retire_cnt, 2);

        // Fence drains 5 cycles, times out once after 4, then completes.
        do_reset();
        @(negedge clk);
        valid = 4'h1; cls = cl(FENCE, ALU, ALU, ALU); no_st = 0;
        #1;
        chk("fn.idle.ack", ack, 0);
        chk("fn.idle.fence", fence, 0);
        n_to = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            chk($sformatf("fn.d%0d.ack", k), ack, 0);
            chk($sformatf("fn.d%0d.to", k), fence_to, (k == 4));
            if (fence_to) n_to++;
        end
        @(negedge clk);
        no_st = 1;
        #1;
        chk("fn.ack", ack, 4'h1);
        chk("fn.fence", fence, 1);
        chk("fn.flush", flush, 1);
        chk("fn.we", {we_gpr, we_fpr}, 0);
        chk("fn.to_count", n_to, 1);
        @(negedge clk);
        valid = 0;
        #1;
        chk("fn.after.fence", fence, 0);
        chk("fn.cnt", retire_cnt, 1);

        // AMO waits, holds under halt, then commits the AMO result.
        do_reset();
        @(negedge clk);
        valid = 4'h1; cls = cl(AMO, ALU, ALU, ALU); amo_result = 64'hDEAD;
        #1;
        chk("amo.idle.vc", amo_vc, 0);
        chk("amo.idle.ack", ack, 0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            chk($sformatf("amo.w%0d.vc", k), amo_vc, 1);
            chk($sformatf("amo.w%0d.ack", k), ack, 0);
        end
        @(negedge clk);
        halt = 1; amo_ack = 1;
        #1;
        chk("amo.halt.ack", ack, 0);
        @(negedge clk);
        halt = 0;
        #1;
        chk("amo.held.vc", amo_vc, 1);
        chk("amo.ack", ack, 4'h1);
        chk("amo.wdata", wdata[63:0], 64'hDEAD);
        chk("amo.flush", flush, 1);
        chk("amo.we_gpr", we_gpr, 4'h1);
        @(negedge clk);
        amo_ack = 0; valid = 0;
        #1;
        chk("amo.after.vc", amo_vc, 0);

        // FP flags accumulate; clear with new flags keeps only the new ones.
        do_reset();
        @(negedge clk);
        valid = 4'h3; cls = cl(FPU, FPU, ALU, ALU); fpr = 4'h3;
        fflags = {5'd0, 5'd0, 5'b10000, 5'b00001};
        #1;
        chk("ff.ack", ack, 4'h3);
        chk("ff.we_fpr", we_fpr, 4'h3);
        @(negedge clk);
        valid = 0; fflags = 0;
        #1;
        chk("ff.acc", facc, 5'b10001);
        @(negedge clk);
        valid = 4'h1; fflags = {15'd0, 5'b00100}; fclr = 1;
        @(negedge clk);
        valid = 0; fflags = 0; fclr = 0;
        #1;
        chk("ff.clr_new", facc, 5'b00100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
